// File: rtl/mem_arbiter_pkg.sv
// mem_arbiter_pkg: shared CPU definitions used by the memory arbiter.
// Holds the access-size and arbiter FSM encodings plus the alignment rule.
package mem_arbiter_pkg;
   typedef enum logic [1:0] {
      SIZE_BYTE = 2'd0,
      SIZE_HALF = 2'd1,
      SIZE_WORD = 2'd2
   } size_e;
   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      BUSY_IF = 2'd1,
      BUSY_DM = 2'd2,
      ERR     = 2'd3
   } state_e;
   function automatic logic misaligned(input size_e size, input logic [1:0] lo);
      return size == SIZE_WORD ? |lo : size == SIZE_HALF ? lo[0] : 1'b0;
   endfunction
endpackage

// File: rtl/mem_arbiter_if.sv
// mem_arbiter_if: fetch, data and shared memory port signals of the arbiter.
// slave is the arbiter's view; master is the view of the requesters and memory.
interface mem_arbiter_if;
   import mem_arbiter_pkg::*;
   logic        if_req;
   logic [31:0] if_addr;
   logic        if_kill;
   logic        if_gnt;
   logic        if_valid;
   logic [31:0] if_rdata;
   logic        dm_req;
   logic        dm_we;
   size_e       dm_size;
   logic [31:0] dm_addr;
   logic [31:0] dm_wdata;
   logic        dm_gnt;
   logic        dm_valid;
   logic        dm_err;
   logic [31:0] dm_rdata;
   logic        mem_en;
   logic        mem_we;
   size_e       mem_size;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   modport slave (
      input  if_req, if_addr, if_kill, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
      output if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_err, dm_rdata,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata
   );
   modport master (
      output if_req, if_addr, if_kill, dm_req, dm_we, dm_size, dm_addr, dm_wdata, mem_rdata,
      input  if_gnt, if_valid, if_rdata, dm_gnt, dm_valid, dm_err, dm_rdata,
             mem_en, mem_we, mem_size, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mem_arbiter_lat.sv
// mem_lat_counter: memory latency countdown, loaded with MEM_LAT-1 on a grant.
// zero marks the response cycle of the transaction in flight.
module mem_lat_counter #(
   parameter int MEM_LAT = 2
) (
   input  logic clk,
   input  logic rst,
   input  logic load,
   output logic zero
);
   logic [3:0] cnt_d, cnt_q;
   always_comb begin
      cnt_d = load ? 4'(MEM_LAT - 1) : (cnt_q != 4'd0 ? cnt_q - 4'd1 : cnt_q);
      zero  = cnt_q == 4'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) cnt_q <= '0;
      else     cnt_q <= cnt_d;
   end
endmodule

// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one memory port between fetch and data accesses.
// Data wins ties unless fetch has lost STARVE_MAX arbitrations in a row.
module mem_arbiter
   import mem_arbiter_pkg::*;
#(
   parameter int MEM_LAT    = 2,
   parameter int STARVE_MAX = 4
) (
   input logic          clk,
   input logic          rst,
   mem_arbiter_if.slave b
);
   state_e     state_d, state_q;
   logic [3:0] starve_d, starve_q;
   logic       kill_d, kill_q, we_d, we_q;
   logic       lat_zero, resp, arb, mis, if_win, dm_win, dm_go, dm_done;
   mem_lat_counter #(.MEM_LAT(MEM_LAT)) u_lat (
      .clk  (clk),
      .rst  (rst),
      .load (if_win | dm_win),
      .zero (lat_zero)
   );
   // Grants and responses are combinational so a new grant can share a response cycle.
   always_comb begin
      resp     = (state_q == BUSY_IF || state_q == BUSY_DM) && lat_zero;
      arb      = !rst && (state_q == IDLE || resp);
      mis      = misaligned(b.dm_size, b.dm_addr[1:0]);
      if_win   = arb && b.if_req && (!b.dm_req || starve_q == 4'(STARVE_MAX));
      dm_win   = arb && b.dm_req && !if_win;
      dm_go    = dm_win && !mis;
      dm_done  = !rst && state_q == BUSY_DM && lat_zero;
      state_d  = if_win ? BUSY_IF : dm_win ? (mis ? ERR : BUSY_DM) :
                 (resp || state_q == ERR) ? IDLE : state_q;
      starve_d = if_win ? 4'd0 :
                 (arb && b.if_req && starve_q != 4'(STARVE_MAX)) ? starve_q + 4'd1 : starve_q;
      kill_d   = if_win ? 1'b0 : (state_q == BUSY_IF && b.if_kill) ? 1'b1 : kill_q;
      we_d     = dm_win ? b.dm_we : we_q;
      b.if_gnt    = if_win;
      b.if_valid  = !rst && state_q == BUSY_IF && lat_zero && !kill_q && !b.if_kill;
      b.if_rdata  = b.if_valid ? b.mem_rdata : 32'd0;
      b.dm_gnt    = dm_win;
      b.dm_err    = !rst && state_q == ERR;
      b.dm_valid  = dm_done || b.dm_err;
      b.dm_rdata  = (dm_done && !we_q) ? b.mem_rdata : 32'd0;
      b.mem_en    = if_win || dm_go;
      b.mem_we    = dm_go && b.dm_we;
      b.mem_size  = if_win ? SIZE_WORD : dm_go ? b.dm_size : SIZE_BYTE;
      b.mem_addr  = if_win ? b.if_addr : dm_go ? b.dm_addr : 32'd0;
      b.mem_wdata = (dm_go && b.dm_we) ? b.dm_wdata : 32'd0;
   end
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q  <= IDLE;
         starve_q <= '0;
         kill_q   <= 1'b0;
         we_q     <= 1'b0;
      end else begin
         state_q  <= state_d;
         starve_q <= starve_d;
         kill_q   <= kill_d;
         we_q     <= we_d;
      end
   end
endmodule

// File: tb/tb_mem_arbiter.sv
// tb_mem_arbiter: directed scenarios plus random traffic for mem_arbiter,
// checked every cycle against a transaction-level model with due-cycle timestamps.
module tb_mem_arbiter;
   import mem_arbiter_pkg::*;
   localparam int LAT  = 2;
   localparam int SMAX = 4;
   logic clk = 1'b0;
   logic rst = 1'b1;
   mem_arbiter_if bus();
   mem_arbiter #(.MEM_LAT(LAT), .STARVE_MAX(SMAX)) dut (.clk(clk), .rst(rst), .b(bus));
   always #5 clk = ~clk;
   int n_chk = 0, n_pass = 0, cyc = 0;
   // Model: one outstanding transaction of kind 0=fetch, 1=data, 2=error, finishing at m_due.
   bit m_act, m_kill, m_we;
   int m_kind, m_due, m_starve;
   bit e_if_gnt, e_dm_gnt;
   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
   endtask
   task automatic eval();
      bit resp, err, arb, mis, ifw, dmw, go, ifv, dmv;
      int al;
      #1;
      resp = m_act && m_kind != 2 && cyc == m_due;
      err  = m_act && m_kind == 2;
      arb  = !rst && (!m_act || resp);
      al   = bus.dm_size == SIZE_WORD ? 4 : bus.dm_size == SIZE_HALF ? 2 : 1;
      mis  = (int'(bus.dm_addr[3:0]) % al) != 0;
      ifw  = arb && bus.if_req && (!bus.dm_req || m_starve == SMAX);
      dmw  = arb && bus.dm_req && !ifw;
      go   = dmw && !mis;
      ifv  = !rst && resp && m_kind == 0 && !m_kill && !bus.if_kill;
      dmv  = !rst && ((resp && m_kind == 1) || err);
      check("if_gnt", bus.if_gnt, ifw);
      check("dm_gnt", bus.dm_gnt, dmw);
      check("mem_en", bus.mem_en, ifw || go);
      if (ifw || go || rst) begin
         check("mem_addr", bus.mem_addr, rst ? 32'd0 : ifw ? bus.if_addr : bus.dm_addr);
         check("mem_size", bus.mem_size, rst ? 32'd0 : ifw ? 32'd2 : 32'(bus.dm_size));
         check("mem_we", bus.mem_we, go && bus.dm_we);
      end
      if ((go && bus.dm_we) || rst) check("mem_wdata", bus.mem_wdata, rst ? 32'd0 : bus.dm_wdata);
      check("if_valid", bus.if_valid, ifv);
      check("if_rdata", bus.if_rdata, ifv ? bus.mem_rdata : 32'd0);
      check("dm_valid", bus.dm_valid, dmv);
      check("dm_err", bus.dm_err, !rst && err);
      check("dm_rdata", bus.dm_rdata, (dmv && !err && !m_we) ? bus.mem_rdata : 32'd0);
      if (rst) begin
         m_act = 0;
         m_starve = 0;
      end else begin
         if (m_act && m_kind == 0 && bus.if_kill) m_kill = 1;
         if (resp || err) m_act = 0;
         if (ifw || dmw) begin
            m_act  = 1;
            m_kind = ifw ? 0 : mis ? 2 : 1;
            m_due  = cyc + (m_kind == 2 ? 1 : LAT);
            m_kill = 0;
            m_we   = dmw && bus.dm_we;
         end
         if (ifw) m_starve = 0;
         else if (arb && bus.if_req && m_starve < SMAX) m_starve++;
      end
      e_if_gnt = ifw;
      e_dm_gnt = dmw;
      cyc++;
   endtask
   task automatic step();
      eval();
      @(negedge clk);
   endtask
   task automatic rand_drive();
      if (!bus.if_req || e_if_gnt || $urandom_range(0, 9) == 0) begin
         bus.if_req  = $urandom_range(0, 2) != 0;
         bus.if_addr = $urandom;
      end
      if (!bus.dm_req || e_dm_gnt || $urandom_range(0, 9) == 0) begin
         bus.dm_req   = $urandom_range(0, 2) != 0;
         bus.dm_we    = $urandom_range(0, 1) != 0;
         bus.dm_size  = size_e'($urandom_range(0, 2));
         bus.dm_addr  = $urandom & ($urandom_range(0, 1) != 0 ? 32'hFFFF_FFFC : 32'hFFFF_FFFF);
         bus.dm_wdata = $urandom;
      end
      bus.if_kill   = $urandom_range(0, 5) == 0;
      bus.mem_rdata = $urandom;
      rst           = $urandom_range(0, 59) == 0;
   endtask
   initial begin
      int k, last;
      bus.if_req = 0; bus.if_addr = 0; bus.if_kill = 0;
      bus.dm_req = 0; bus.dm_we = 0; bus.dm_size = SIZE_WORD; bus.dm_addr = 0; bus.dm_wdata = 0;
      bus.mem_rdata = 32'h0BAD_0BAD;
      @(negedge clk);
      repeat (2) step();
      rst = 0;
      // single fetch
      bus.if_req = 1; bus.if_addr = 32'h100; eval();
      check("fetch_gnt", bus.if_gnt, 1); check("fetch_addr", bus.mem_addr, 32'h100);
      @(negedge clk);
      bus.if_req = 0; step();
      bus.mem_rdata = 32'h1234_5678; eval();
      check("fetch_valid", bus.if_valid, 1); check("fetch_rdata", bus.if_rdata, 32'h1234_5678);
      @(negedge clk);
      // both requesting continuously: DM x4 then IF, one grant every LAT cycles
      bus.if_req = 1; bus.if_addr = 32'h104;
      bus.dm_req = 1; bus.dm_we = 0; bus.dm_size = SIZE_WORD; bus.dm_addr = 32'h200;
      k = 0; last = 0;
      for (int i = 0; i < 24; i++) begin
         eval();
         if (bus.if_gnt || bus.dm_gnt) begin
            check("order_if", bus.if_gnt, k % 5 == 4);
            if (k > 0) check("grant_gap", i - last, LAT);
            last = i;
            k++;
         end
         @(negedge clk);
      end
      check("grant_count", k, 12);
      bus.if_req = 0; bus.dm_req = 0; step(); step();
      // misaligned word
      bus.dm_req = 1; bus.dm_addr = 32'h102; bus.dm_size = SIZE_WORD; eval();
      check("mis_gnt", bus.dm_gnt, 1); check("mis_mem_en", bus.mem_en, 0);
      @(negedge clk);
      bus.dm_req = 0; eval();
      check("mis_valid", bus.dm_valid, 1); check("mis_err", bus.dm_err, 1); check("mis_no_mem", bus.mem_en, 0);
      @(negedge clk);
      // killed fetch with data waiting
      bus.if_req = 1; bus.if_addr = 32'h300; eval();
      check("kill_if_gnt", bus.if_gnt, 1);
      @(negedge clk);
      bus.if_req = 0; bus.if_kill = 1; bus.dm_req = 1; bus.dm_addr = 32'h400; eval();
      check("kill_dm_wait", bus.dm_gnt, 0);
      @(negedge clk);
      bus.if_kill = 0; bus.mem_rdata = 32'hCAFE_F00D; eval();
      check("kill_no_valid", bus.if_valid, 0); check("kill_dm_gnt", bus.dm_gnt, 1);
      @(negedge clk);
      bus.dm_req = 0; step(); step();
      // reset in the middle of a data transaction
      bus.dm_req = 1; bus.dm_addr = 32'h80; eval();
      check("rst_dm_gnt", bus.dm_gnt, 1);
      @(negedge clk);
      bus.dm_req = 0; rst = 1; bus.if_req = 1; bus.if_addr = 32'h500; eval();
      check("rst_if_gnt", bus.if_gnt, 0); check("rst_mem_en", bus.mem_en, 0);
      @(negedge clk);
      rst = 0; eval();
      check("rst_no_valid", bus.dm_valid, 0); check("rst_new_gnt", bus.if_gnt, 1);
      @(negedge clk);
      bus.if_req = 0; step(); step();
      // store
      bus.dm_req = 1; bus.dm_we = 1; bus.dm_addr = 32'h40; bus.dm_size = SIZE_WORD;
      bus.dm_wdata = 32'hDEAD_BEEF; eval();
      check("st_we", bus.mem_we, 1); check("st_wdata", bus.mem_wdata, 32'hDEAD_BEEF);
      @(negedge clk);
      bus.dm_req = 0; step();
      bus.mem_rdata = 32'h5555_AAAA; eval();
      check("st_valid", bus.dm_valid, 1); check("st_rdata", bus.dm_rdata, 0);
      @(negedge clk);
      repeat (1500) begin
         rand_drive();
         step();
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end
endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 The block SHALL have parameter MEM_LAT, default 2, meaning cycles from grant to response; legal range 1..15.
REQ-002 The block SHALL have parameter STARVE_MAX, default 4, meaning the number of consecutive lost arbitrations after which fetch is forced to win; legal range 1..15.
REQ-003 The block SHALL have port clk  in  1  system clock; all state updates on the rising edge.
REQ-004 The block SHALL have port rst  in  1  reset, synchronous, active-high.
REQ-005 The block SHALL have port if_req  in  1  fetch request.
REQ-006 The block SHALL have port if_addr  in  32  fetch address.
REQ-007 The block SHALL have port if_kill  in  1  cancels the outstanding fetch response (branch redirect).
REQ-008 The block SHALL have ports if_gnt  out  1, if_valid  out  1, if_rdata  out  32, giving fetch grant, response valid and instruction word.
REQ-009 The block SHALL have ports dm_req  in  1, dm_we  in  1, dm_size  in  2, dm_addr  in  32, dm_wdata  in  32, giving the data request.
REQ-010 The block SHALL have ports dm_gnt  out  1, dm_valid  out  1, dm_err  out  1, dm_rdata  out  32, giving data grant, completion, misalignment error and load data.
REQ-011 The block SHALL have ports mem_en  out  1, mem_we  out  1, mem_size  out  2, mem_addr  out  32, mem_wdata  out  32, mem_rdata  in  32, forming the single shared memory port.

Function
REQ-012 The FSM SHALL have the states IDLE, BUSY_IF, BUSY_DM and ERR.
REQ-013 An arbitration cycle SHALL be any cycle in IDLE, or the final (response) cycle of BUSY_IF or BUSY_DM.
REQ-014 Data SHALL beat fetch when both request, unless the starvation counter equals STARVE_MAX; in that case fetch SHALL win.
REQ-015 The starvation counter SHALL increment when if_req loses arbitration, SHALL clear when fetch is granted, and SHALL saturate at STARVE_MAX.
REQ-016 On a grant, gnt SHALL pulse for exactly one cycle, and mem_en SHALL be 1 in that same cycle only, with mem_addr/size/we/wdata taken combinationally from the winning requester.
REQ-017 A fetch SHALL use size word and we=0.
REQ-018 The requester SHALL hold req and operands stable until gnt; a drop of req before gnt SHALL withdraw the request without any memory access.
REQ-019 The response valid SHALL be asserted for one cycle exactly MEM_LAT cycles after the grant cycle, with rdata = mem_rdata of that cycle.
REQ-020 A store completion SHALL assert dm_valid with dm_rdata = 0.
REQ-021 rdata outputs SHALL be 0 whenever the corresponding valid is 0.
REQ-022 A data request with dm_size = word and addr[1:0] != 0, or dm_size = half and addr[0] != 0, SHALL be granted without mem_en, go to ERR, and assert dm_valid and dm_err together in the next cycle.
REQ-023 if_kill asserted in any BUSY_IF cycle, including the response cycle, SHALL suppress if_valid for that transaction while the memory timing still runs to completion.
REQ-024 if_kill in IDLE SHALL have no effect.
REQ-025 Back-to-back operation: a grant SHALL be allowed in a response cycle, giving sustained throughput of one access per MEM_LAT cycles.
REQ-026 At most one transaction SHALL be outstanding at any time.

Reset
REQ-027 While rst=1, on each clock edge the state SHALL become IDLE, and both latency and starvation counters SHALL become 0.
REQ-028 While in reset, all outputs SHALL be 0.
REQ-029 A reset mid-transaction SHALL abandon it, with no valid emitted afterwards.
REQ-030 The first grant SHALL be possible in the first cycle after rst is deasserted.

Structure
REQ-031 The size encodings (SIZE_BYTE, SIZE_HALF, SIZE_WORD) and the FSM state encodings SHALL reside in the shared CPU definitions package.
REQ-032 The latency countdown SHALL be a sub-module, mem_lat_counter (load MEM_LAT-1 on grant, count down, flag zero).

Verification
REQ-033 MEM_LAT=2, if_req only with addr 0x100 at cycle 0 -> if_gnt at cycle 0, mem_en=1 with mem_addr=0x100 at cycle 0, if_valid at cycle 2 with if_rdata=mem_rdata.
REQ-034 if_req and dm_req held continuously, STARVE_MAX=4 -> grant order DM,DM,DM,DM,IF,DM..., one grant every 2 cycles.
REQ-035 dm_size=word, dm_addr=0x102 -> dm_gnt with mem_en=0, then dm_valid=1 and dm_err=1 in the next cycle, with no memory access.
REQ-036 Fetch granted at cycle 0 with if_kill=1 at cycle 1 -> no if_valid; a data request pending is granted at cycle 2.
REQ-037 rst=1 at cycle 1 of a BUSY_DM transaction -> all outputs 0, no dm_valid at cycle 2, and a new grant is possible at cycle 2 after rst deasserts.
REQ-038 Store with dm_wdata=0xDEADBEEF at addr 0x40 -> mem_we=1 and mem_wdata=0xDEADBEEF in the grant cycle, then dm_valid with dm_rdata=0 after MEM_LAT cycles.
